// File: rtl/oam_arbiter_if.sv
// rtl/oam_arbiter_if.sv - scanner, CPU and OAM memory port bundle for oam_arbiter
interface oam_arbiter_if #(
    parameter int OAM_ADDR_SIZE = 6
);
    logic                     scan_active;
    logic [OAM_ADDR_SIZE-1:0] scan_addr;
    logic [31:0]              scan_data;
    logic                     scan_stall;
    logic                     cpu_req;
    logic                     cpu_we;
    logic [OAM_ADDR_SIZE-1:0] cpu_addr;
    logic [31:0]              cpu_wdata;
    logic                     cpu_gnt;
    logic [31:0]              cpu_rdata;
    logic                     cpu_rvalid;
    logic [OAM_ADDR_SIZE-1:0] oam_addr;
    logic                     oam_we;
    logic [31:0]              oam_wdata;
    logic [31:0]              oam_rdata;
    logic [15:0]              stall_count;

    modport master (
        input  scan_active, scan_addr, cpu_req, cpu_we, cpu_addr, cpu_wdata, oam_rdata,
        output scan_data, scan_stall, cpu_gnt, cpu_rdata, cpu_rvalid,
               oam_addr, oam_we, oam_wdata, stall_count
    );

    modport slave (
        output scan_active, scan_addr, cpu_req, cpu_we, cpu_addr, cpu_wdata, oam_rdata,
        input  scan_data, scan_stall, cpu_gnt, cpu_rdata, cpu_rvalid,
               oam_addr, oam_we, oam_wdata, stall_count
    );
endinterface

// File: rtl/oam_arbiter.sv
// rtl/oam_arbiter.sv - single-port OAM arbiter, scanner priority with forced CPU grant; OAM_ARB_STATS_EN enables stall_count
module oam_arbiter #(
    parameter int OAM_ADDR_SIZE = 6,
    parameter int STARVE_LIMIT  = 32
) (
    input  logic          clk,
    input  logic          reset,
    oam_arbiter_if.master bus
);
    localparam int CNT_W = $clog2(STARVE_LIMIT) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STARVE_LIMIT - 1);

    typedef enum logic [1:0] {IDLE, SCAN, FORCE} state_t;

    state_t                   state, state_nxt;
    logic [CNT_W-1:0]         starve_cnt, starve_cnt_nxt;
    logic                     cpu_rd_q, scan_rd_q;
    logic [31:0]              cpu_rdata_q, scan_data_q;
    logic                     gnt, stall, mux_we;
    logic [OAM_ADDR_SIZE-1:0] mux_addr;
    logic [31:0]              mux_wdata;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            starve_cnt  <= '0;
            cpu_rd_q    <= 1'b0;
            scan_rd_q   <= 1'b0;
            cpu_rdata_q <= 32'h0;
            scan_data_q <= 32'h0;
        end else begin
            state       <= state_nxt;
            starve_cnt  <= starve_cnt_nxt;
            cpu_rd_q    <= gnt & ~bus.cpu_we;
            scan_rd_q   <= (state == SCAN);
            cpu_rdata_q <= bus.cpu_rdata;
            scan_data_q <= bus.scan_data;
        end
    end

    always_comb begin
        state_nxt      = state;
        starve_cnt_nxt = '0;
        gnt            = 1'b0;
        stall          = 1'b0;
        mux_we         = 1'b0;
        mux_addr       = '0;
        mux_wdata      = 32'h0;
        case (state)
            IDLE: begin
                if (bus.cpu_req) begin
                    gnt       = 1'b1;
                    mux_addr  = bus.cpu_addr;
                    mux_we    = bus.cpu_we;
                    mux_wdata = bus.cpu_wdata;
                end
                if (bus.scan_active)
                    state_nxt = SCAN;
            end
            SCAN: begin
                mux_addr = bus.scan_addr;
                if (!bus.scan_active) begin
                    state_nxt = IDLE;
                end else if (bus.cpu_req) begin
                    // Counter stops at CNT_LAST, which always fits in CNT_W bits, so it cannot wrap.
                    if (starve_cnt >= CNT_LAST)
                        state_nxt = FORCE;
                    else
                        starve_cnt_nxt = starve_cnt + 1'b1;
                end
            end
            FORCE: begin
                gnt       = bus.cpu_req;
                stall     = 1'b1;
                mux_addr  = bus.cpu_addr;
                mux_we    = bus.cpu_req & bus.cpu_we;
                mux_wdata = bus.cpu_wdata;
                state_nxt = bus.scan_active ? SCAN : IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Port drives are gated by reset so an in-flight access drops the moment reset rises.
    assign bus.cpu_gnt    = gnt & ~reset;
    assign bus.scan_stall = stall & ~reset;
    assign bus.oam_we     = mux_we & ~reset;
    assign bus.oam_addr   = reset ? '0 : mux_addr;
    assign bus.oam_wdata  = reset ? 32'h0 : mux_wdata;
    assign bus.cpu_rvalid = cpu_rd_q;
    assign bus.cpu_rdata  = cpu_rd_q ? bus.oam_rdata : cpu_rdata_q;
    assign bus.scan_data  = scan_rd_q ? bus.oam_rdata : scan_data_q;

`ifdef OAM_ARB_STATS_EN
    logic [15:0] stall_cnt_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            stall_cnt_q <= 16'h0;
        else if (state == FORCE && stall_cnt_q != 16'hFFFF)
            stall_cnt_q <= stall_cnt_q + 16'd1;
    end

    assign bus.stall_count = stall_cnt_q;
`else
    assign bus.stall_count = 16'h0;
`endif
endmodule

// File: doc/oam_arbiter.md
OAM_ARBITER -- requirements
Module: oam_arbiter

Interface
REQ-001 SHALL have parameter OAM_ADDR_SIZE, default 6, OAM word address width (64 entries of 32 bits).
REQ-002 SHALL have parameter STARVE_LIMIT, default 32, number of consecutive cycles a CPU request may wait during a scan before a forced grant.
REQ-003 SHALL have port clk  input  1  clock; all state changes on its rising edge.
REQ-004 SHALL have port reset  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port scan_active  input  1  line scanner is walking OAM and owns the port by default.
REQ-006 SHALL have port scan_addr  input  OAM_ADDR_SIZE  scanner read address.
REQ-007 SHALL have port scan_data  output  32  OAM read data returned to the scanner.
REQ-008 SHALL have port scan_stall  output  1  scanner must hold scan_addr this cycle; no read was issued for it.
REQ-009 SHALL have ports cpu_req, cpu_we  input  1 each  CPU access request and write-enable.
REQ-010 SHALL have ports cpu_addr  input  OAM_ADDR_SIZE and cpu_wdata  input  32  CPU address and write data.
REQ-011 SHALL have port cpu_gnt  output  1  CPU access issued to OAM this cycle.
REQ-012 SHALL have ports cpu_rdata  output  32 and cpu_rvalid  output  1  CPU read data and its valid strobe.
REQ-013 SHALL have ports oam_addr  output  OAM_ADDR_SIZE, oam_we  output  1, oam_wdata  output  32  single OAM memory port.
REQ-014 SHALL have port oam_rdata  input  32  OAM read data, valid one cycle after the address.
REQ-015 SHALL have port stall_count  output  16  number of forced CPU grants (see Configuration).

Function
REQ-016 SHALL implement states IDLE, SCAN, FORCE; oam_addr/oam_we/cpu_gnt/scan_stall combinational from state and inputs.
REQ-017 IDLE (scan_active=0): cpu_req=1 SHALL give cpu_gnt=1 the same cycle, oam_addr=cpu_addr, oam_we=cpu_we, oam_wdata=cpu_wdata.
REQ-018 IDLE with scan_active=1 SHALL move to SCAN next cycle; an IDLE CPU grant in that same cycle completes.
REQ-019 SCAN: oam_addr=scan_addr, oam_we=0, cpu_gnt=0, scan_stall=0; a starvation counter increments each cycle cpu_req=1 and clears when cpu_req=0.
REQ-020 SCAN with counter reaching STARVE_LIMIT-1 while cpu_req=1 SHALL move to FORCE next cycle.
REQ-021 FORCE SHALL last exactly one cycle: cpu_gnt=1, scan_stall=1, CPU drives the port, counter cleared, then return to SCAN (or IDLE if scan_active=0).
REQ-022 SCAN with scan_active=0 SHALL return to IDLE next cycle; counter cleared.
REQ-023 cpu_req dropping while in FORCE SHALL still cancel the grant: cpu_gnt=cpu_req, oam_we=cpu_req&cpu_we.
REQ-024 A granted read SHALL produce cpu_rvalid=1 exactly one cycle later with cpu_rdata=oam_rdata; writes never raise cpu_rvalid.
REQ-025 scan_data SHALL equal oam_rdata registered-through: valid one cycle after a non-stalled SCAN cycle; scan_data holds its last value during stall cycles.
REQ-026 Starvation counter SHALL be $clog2(STARVE_LIMIT)+1 bits and never wrap.

Reset
REQ-027 Reset SHALL force state IDLE, counter 0, cpu_rvalid 0, cpu_gnt 0, scan_stall 0, oam_we 0, oam_addr 0, scan_data 0, cpu_rdata 0, stall_count 0.
REQ-028 Reset mid-FORCE SHALL abort the access; oam_we deasserts asynchronously with reset.

Configuration
REQ-029 With macro OAM_ARB_STATS_EN defined, stall_count SHALL increment once per FORCE cycle, saturating at 16'hFFFF.
REQ-030 Without OAM_ARB_STATS_EN, stall_count SHALL be constant 0 and no counter register exists.

Verification
REQ-031 scan_active=0, cpu write addr 5 data 32'hDEADBEEF -> cpu_gnt=1 same cycle, oam_we=1, oam_addr=5, no cpu_rvalid.
REQ-032 scan_active=0, cpu read addr 5 -> cpu_rvalid=1 next cycle, cpu_rdata=32'hDEADBEEF.
REQ-033 scan_active=1, cpu_req held, STARVE_LIMIT=32 -> cpu_gnt and scan_stall high for one cycle after 32 cycles of waiting, every 33 cycles thereafter.
REQ-034 scan_active=1 sweeping addr 0..63 -> scan_data matches OAM contents one cycle after each address; no read lost across a stall.
REQ-035 reset asserted during FORCE -> all outputs zero immediately; state IDLE after release.
REQ-036 OAM_ARB_STATS_EN defined, 3 forced grants -> stall_count=3; undefined -> stall_count=0.
